// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared types and line-geometry helper for the memory bus controller
package mem_bus_pkg;

    typedef enum logic {
        OWN_ICACHE = 1'b0,
        OWN_DCACHE = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        READ  = 2'd2,
        WRITE = 2'd3
    } state_e;

    // Number of byte-address bits covered by one cache line.
    function automatic int line_offset_w(input int burst_len, input int data_w);
        return $clog2(burst_len * data_w / 8);
    endfunction

endpackage

// File: rtl/mem_bus_controller_arb.sv
// rtl/mem_bus_controller_arb.sv - two-requester round-robin arbiter with last-owner memory
import mem_bus_pkg::*;

module rr_arbiter2 (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   req_ic,
    input  logic   req_dc,
    input  logic   accept,
    output logic   gnt_ic,
    output logic   gnt_dc,
    output owner_e winner
);

    owner_e last_owner;

    // On contention the requester that did not win last time gets the bus.
    always_comb begin
        winner = OWN_ICACHE;
        if (req_ic && req_dc) begin
            winner = (last_owner == OWN_ICACHE) ? OWN_DCACHE : OWN_ICACHE;
        end else if (req_dc) begin
            winner = OWN_DCACHE;
        end
    end

    assign gnt_ic = req_ic && (winner == OWN_ICACHE);
    assign gnt_dc = req_dc && (winner == OWN_DCACHE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_owner <= OWN_ICACHE;
        end else if (accept) begin
            last_owner <= winner;
        end
    end

endmodule

// File: rtl/mem_bus_controller.sv
// rtl/mem_bus_controller.sv - arbitrates I/D-cache line bursts onto one external memory port
import mem_bus_pkg::*;

module mem_bus_controller #(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int BURST_LEN = 8
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              ic_req_valid,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_req_ready,
    output logic              ic_resp_valid,
    output logic [DATA_W-1:0] ic_resp_data,
    output logic              ic_resp_last,

    input  logic              dc_req_valid,
    input  logic              dc_req_we,
    input  logic [ADDR_W-1:0] dc_req_addr,
    output logic              dc_req_ready,
    input  logic              dc_wdata_valid,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_wdata_ready,
    output logic              dc_resp_valid,
    output logic [DATA_W-1:0] dc_resp_data,
    output logic              dc_resp_last,
    output logic              dc_wr_done,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_we,
    output logic              mem_wdata_valid,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_wdata_ready,
    input  logic              mem_rdata_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int LINE_OFFSET_W = line_offset_w(BURST_LEN, DATA_W);
    localparam int CNT_W         = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK =
        ~((ADDR_W'(1) << LINE_OFFSET_W) - ADDR_W'(1));

    state_e            state;
    owner_e            owner;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  beat_cnt;

    logic              in_idle;
    logic              gnt_ic;
    logic              gnt_dc;
    logic              accept;
    owner_e            winner;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;
    logic              rd_beat;
    logic              wr_beat;
    logic              beat_last;

    assign in_idle = (state == IDLE);

    // Requests are masked outside IDLE so the grant stays locked for the burst.
    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req_ic  (in_idle && ic_req_valid),
        .req_dc  (in_idle && dc_req_valid),
        .accept  (accept),
        .gnt_ic  (gnt_ic),
        .gnt_dc  (gnt_dc),
        .winner  (winner)
    );

    assign ic_req_ready = gnt_ic;
    assign dc_req_ready = gnt_dc;
    assign accept       = gnt_ic || gnt_dc;

    assign sel_addr  = (winner == OWN_DCACHE) ? dc_req_addr : ic_req_addr;
    assign sel_we    = (winner == OWN_DCACHE) && dc_req_we;

    assign rd_beat   = (state == READ) && mem_rdata_valid;
    assign wr_beat   = (state == WRITE) && dc_wdata_valid && mem_wdata_ready;
    assign beat_last = (beat_cnt == LAST_BEAT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            owner    <= OWN_ICACHE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner  <= winner;
                        we_q   <= sel_we;
                        addr_q <= sel_addr & LINE_MASK;
                        state  <= ADDR;
                    end
                end
                ADDR: begin
                    if (mem_req_ready) begin
                        state <= we_q ? WRITE : READ;
                    end
                end
                READ: begin
                    if (rd_beat) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (beat_last) begin
                            state <= IDLE;
                        end
                    end
                end
                WRITE: begin
                    if (wr_beat) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (beat_last) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read beats are registered once and steered only to the burst owner.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ic_resp_valid <= 1'b0;
            ic_resp_data  <= '0;
            ic_resp_last  <= 1'b0;
            dc_resp_valid <= 1'b0;
            dc_resp_data  <= '0;
            dc_resp_last  <= 1'b0;
            dc_wr_done    <= 1'b0;
        end else begin
            ic_resp_valid <= rd_beat && (owner == OWN_ICACHE);
            ic_resp_last  <= rd_beat && (owner == OWN_ICACHE) && beat_last;
            dc_resp_valid <= rd_beat && (owner == OWN_DCACHE);
            dc_resp_last  <= rd_beat && (owner == OWN_DCACHE) && beat_last;
            dc_wr_done    <= wr_beat && beat_last;
            if (rd_beat && (owner == OWN_ICACHE)) begin
                ic_resp_data <= mem_rdata;
            end
            if (rd_beat && (owner == OWN_DCACHE)) begin
                dc_resp_data <= mem_rdata;
            end
        end
    end

    assign mem_req_valid   = (state == ADDR);
    assign mem_req_addr    = addr_q;
    assign mem_req_we      = we_q;
    assign mem_wdata_valid = (state == WRITE) && dc_wdata_valid;
    assign mem_wdata       = (state == WRITE) ? dc_wdata : '0;
    assign dc_wdata_ready  = (state == WRITE) && mem_wdata_ready;

endmodule

// File: tb/tb_mem_bus_controller.sv
// tb/tb_mem_bus_controller.sv - directed and randomized self-checking bench for mem_bus_controller
module tb_mem_bus_controller;

    localparam int BL = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ic_req_valid = 1'b0;
    logic [63:0] ic_req_addr = '0;
    logic        ic_req_ready;
    logic        ic_resp_valid;
    logic [63:0] ic_resp_data;
    logic        ic_resp_last;
    logic        dc_req_valid = 1'b0;
    logic        dc_req_we = 1'b0;
    logic [63:0] dc_req_addr = '0;
    logic        dc_req_ready;
    logic        dc_wdata_valid = 1'b0;
    logic [63:0] dc_wdata = '0;
    logic        dc_wdata_ready;
    logic        dc_resp_valid;
    logic [63:0] dc_resp_data;
    logic        dc_resp_last;
    logic        dc_wr_done;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [63:0] mem_req_addr;
    logic        mem_req_we;
    logic        mem_wdata_valid;
    logic [63:0] mem_wdata;
    logic        mem_wdata_ready = 1'b0;
    logic        mem_rdata_valid = 1'b0;
    logic [63:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;
    bit tb_last_dc = 1'b0;

    always #5 clk = ~clk;

    mem_bus_controller dut (
        .clk(clk), .reset_n(reset_n),
        .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
        .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data), .ic_resp_last(ic_resp_last),
        .dc_req_valid(dc_req_valid), .dc_req_we(dc_req_we), .dc_req_addr(dc_req_addr),
        .dc_req_ready(dc_req_ready), .dc_wdata_valid(dc_wdata_valid), .dc_wdata(dc_wdata),
        .dc_wdata_ready(dc_wdata_ready), .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
        .dc_resp_last(dc_resp_last), .dc_wr_done(dc_wr_done),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_we(mem_req_we), .mem_wdata_valid(mem_wdata_valid), .mem_wdata(mem_wdata),
        .mem_wdata_ready(mem_wdata_ready), .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] line_of(input logic [63:0] a);
        return a - (a % (BL * 8));
    endfunction

    // Presents requests at a negedge, checks the grant, and lets the next posedge accept it.
    task automatic issue(input bit icv, input logic [63:0] ica, input bit dcv, input bit dwe,
                         input logic [63:0] dca, output bit win_dc);
        win_dc = (icv && dcv) ? !tb_last_dc : dcv;
        ic_req_valid = icv; ic_req_addr = ica;
        dc_req_valid = dcv; dc_req_we = dwe; dc_req_addr = dca;
        #1;
        chk("ic_req_ready", ic_req_ready, !win_dc);
        chk("dc_req_ready", dc_req_ready, win_dc);
        tb_last_dc = win_dc;
        @(negedge clk);
    endtask

    task automatic addr_phase(input logic [63:0] exp_addr, input bit exp_we, input int waits);
        for (int i = 0; i <= waits; i++) begin
            chk("mem_req_valid", mem_req_valid, 1'b1);
            chk("mem_req_addr", mem_req_addr, exp_addr);
            chk("mem_req_we", mem_req_we, exp_we);
            chk("ic_req_ready_busy", ic_req_ready, 1'b0);
            chk("dc_req_ready_busy", dc_req_ready, 1'b0);
            if (i == waits) mem_req_ready = 1'b1;
            @(negedge clk);
        end
        mem_req_ready = 1'b0;
    endtask

    task automatic read_burst(input bit own_dc, input bit directed, input logic [63:0] base);
        int sent = 0;
        int gaps = 0;
        bit pv = 1'b0;
        bit pl = 1'b0;
        logic [63:0] pd = '0;
        while (sent < BL || pv) begin
            @(negedge clk);
            chk("own_resp_valid", own_dc ? dc_resp_valid : ic_resp_valid, pv);
            chk("other_resp_valid", own_dc ? ic_resp_valid : dc_resp_valid, 1'b0);
            chk("own_resp_last", own_dc ? dc_resp_last : ic_resp_last, pv && pl);
            if (pv) chk("own_resp_data", own_dc ? dc_resp_data : ic_resp_data, pd);
            pv = 1'b0;
            if (sent < BL && (directed || gaps >= 3 || $urandom_range(0, 3) != 0)) begin
                pd = directed ? base + 64'(sent) : {$urandom, $urandom};
                mem_rdata = pd;
                mem_rdata_valid = 1'b1;
                pl = (sent == BL - 1);
                pv = 1'b1;
                sent++;
            end else begin
                mem_rdata_valid = 1'b0;
                if (sent < BL) gaps++;
            end
        end
    endtask

    task automatic write_burst(input bit toggle);
        int cnt = 0;
        int cyc = 0;
        while (cnt < BL && cyc < 200) begin
            dc_wdata_valid = toggle ? 1'b1 : ($urandom_range(0, 3) != 0);
            dc_wdata = {$urandom, $urandom};
            mem_wdata_ready = toggle ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            mem_rdata_valid = 1'($urandom_range(0, 1));
            #1;
            chk("mem_wdata_valid", mem_wdata_valid, dc_wdata_valid);
            chk("mem_wdata", mem_wdata, dc_wdata);
            chk("dc_wdata_ready", dc_wdata_ready, mem_wdata_ready);
            chk("dc_wr_done_early", dc_wr_done, 1'b0);
            chk("stray_ic_resp", ic_resp_valid, 1'b0);
            chk("stray_dc_resp", dc_resp_valid, 1'b0);
            if (dc_wdata_valid && mem_wdata_ready) cnt++;
            cyc++;
            @(negedge clk);
        end
        chk("wr_beats", 64'(cnt), 64'(BL));
        mem_rdata_valid = 1'b1;
        dc_wdata_valid = 1'b1;
        mem_wdata_ready = 1'b1;
        #1;
        chk("dc_wr_done", dc_wr_done, 1'b1);
        chk("dc_wdata_ready_idle", dc_wdata_ready, 1'b0);
        chk("mem_wdata_valid_idle", mem_wdata_valid, 1'b0);
        @(negedge clk);
        chk("dc_wr_done_once", dc_wr_done, 1'b0);
        chk("stray_idle_ic", ic_resp_valid, 1'b0);
        chk("stray_idle_dc", dc_resp_valid, 1'b0);
        mem_rdata_valid = 1'b0;
        dc_wdata_valid = 1'b0;
        mem_wdata_ready = 1'b0;
    endtask

    task automatic txn(input bit icv, input logic [63:0] ica, input bit dcv, input bit dwe,
                       input logic [63:0] dca, input bit hold);
        bit w;
        issue(icv, ica, dcv, dwe, dca, w);
        if (!hold) begin
            ic_req_valid = 1'b0;
            dc_req_valid = 1'b0;
        end
        addr_phase(line_of(w ? dca : ica), w && dwe, $urandom_range(0, 2));
        if (w && dwe) write_burst(1'b0);
        else read_burst(w, 1'b0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        bit w;
        logic [63:0] a_ic, a_dc;

        @(negedge clk);
        chk("rst_ic_req_ready", ic_req_ready, 1'b0);
        chk("rst_dc_req_ready", dc_req_ready, 1'b0);
        chk("rst_mem_req_valid", mem_req_valid, 1'b0);
        chk("rst_mem_req_addr", mem_req_addr, 64'h0);
        chk("rst_mem_req_we", mem_req_we, 1'b0);
        chk("rst_ic_resp_valid", ic_resp_valid, 1'b0);
        chk("rst_dc_resp_valid", dc_resp_valid, 1'b0);
        chk("rst_dc_wr_done", dc_wr_done, 1'b0);
        reset_n = 1'b1;

        // Stray read beats while idle must not reach either cache.
        mem_rdata_valid = 1'b1;
        mem_rdata = 64'hDEAD;
        repeat (3) begin
            @(negedge clk);
            chk("stray_idle_ic", ic_resp_valid, 1'b0);
            chk("stray_idle_dc", dc_resp_valid, 1'b0);
        end
        mem_rdata_valid = 1'b0;
        @(negedge clk);

        // I-cache fill with directed beats.
        issue(1'b1, 64'h1004, 1'b0, 1'b0, '0, w);
        ic_req_valid = 1'b0;
        addr_phase(64'h1000, 1'b0, 0);
        read_burst(1'b0, 1'b1, 64'hA0);

        // Both requesting continuously: grants alternate, D-cache first.
        a_ic = {$urandom, $urandom};
        a_dc = {$urandom, $urandom};
        for (int k = 0; k < 10; k++) begin
            chk("alt_expect_dc", 64'(!tb_last_dc), 64'(k % 2 == 0));
            txn(1'b1, a_ic, 1'b1, 1'b0, a_dc, 1'b1);
        end
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;
        @(negedge clk);

        // D-cache writeback with stalled address phase and toggling write-ready.
        issue(1'b1, 64'h5000, 1'b1, 1'b1, 64'h2000, w);
        dc_req_valid = 1'b0;
        addr_phase(64'h2000, 1'b1, 5);
        ic_req_valid = 1'b0;
        write_burst(1'b1);

        // Randomized mix of fills and writebacks.
        for (int k = 0; k < 8; k++) begin
            bit icv, dcv;
            icv = 1'($urandom_range(0, 1));
            dcv = !icv || 1'($urandom_range(0, 1));
            txn(icv, {$urandom, $urandom}, dcv, 1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'b0);
        end

        // Reset in the middle of a read burst.
        issue(1'b1, 64'h3000, 1'b0, 1'b0, '0, w);
        ic_req_valid = 1'b0;
        addr_phase(64'h3000, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            mem_rdata_valid = 1'b1;
            mem_rdata = 64'(i + 1);
            @(negedge clk);
        end
        mem_rdata_valid = 1'b0;
        chk("mid_burst_valid", ic_resp_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("arst_ic_resp_valid", ic_resp_valid, 1'b0);
        chk("arst_ic_resp_data", ic_resp_data, 64'h0);
        chk("arst_ic_resp_last", ic_resp_last, 1'b0);
        chk("arst_mem_req_addr", mem_req_addr, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        tb_last_dc = 1'b0;
        issue(1'b1, 64'h3008, 1'b0, 1'b0, '0, w);
        ic_req_valid = 1'b0;
        addr_phase(64'h3000, 1'b0, 1);
        read_burst(1'b0, 1'b1, 64'hB0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
